rtc_bus_driver: RTL
===================

Name: rtc_bus_driver

Overview:
- Downstream of the RTC access sequencer.
- Converts each sequencer request into one complete multiplexed address/data bus transaction on the external RTC chip: an address phase, then a read or write data phase. Request inputs: dirout, dato, lectura, escritura, write, dir_reg.
- Returns a one-cycle fin pulse to the sequencer after each transaction.
- Read data is presented as a register-file write (reg_wr_en/reg_addr/reg_data) for the time/date register bank.

Parameters:
- T_SETUP, 2, clocks that address or data is driven before its strobe.
- T_STROBE, 8, clocks a strobe (wr_n or rd_n) is held low.
- T_HOLD, 2, clocks that address or data is held after its strobe rises.
- T_GAP, 4, clocks with cs_n high between the address and data phases.
- T_RECOVER, 4, dead clocks after fin before a new request is sampled. Must be >=2.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- dirout  in  8  RTC register address from the sequencer
- dato  in  8  write data from the sequencer
- lectura  in  1  read request (level)
- escritura  in  1  write request (level); has priority over lectura
- write  in  1  capture enable: read data goes to the register file
- dir_reg  in  4  register-file index for captured data
- fin  out  1  one-cycle transaction-done pulse
- cs_n  out  1  chip select, active low
- ad_sel  out  1  0 = address phase, 1 = data phase (A/D line)
- rd_n  out  1  read strobe, active low
- wr_n  out  1  write strobe, active low
- ad_out  out  8  value driven on the AD bus
- ad_oe  out  1  AD bus output enable
- ad_in  in  8  AD bus input
- reg_wr_en  out  1  one-cycle register-file write
- reg_addr  out  4  register-file index
- reg_data  out  8  captured read byte

Behaviour:
- Reset values: cs_n=1, rd_n=1, wr_n=1, ad_sel=0, ad_oe=0, ad_out=0, fin=0, reg_wr_en=0, reg_addr=0, reg_data=0. State returns to IDLE. Reset mid-transaction aborts immediately; no fin is issued.
- All outputs are registered. One shared phase counter, width $clog2 of the largest parameter + 1, reloads on every state entry.
- States:
  - IDLE: if escritura or lectura is high, latch op (escritura wins if both), dirout, dato, write and dir_reg, then go to A_SETUP. Otherwise stay.
  - A_SETUP (T_SETUP): cs_n=0, ad_sel=0, ad_oe=1, ad_out=latched address.
  - A_STROBE (T_STROBE): wr_n=0.
  - A_HOLD (T_HOLD): wr_n=1, address still driven.
  - GAP (T_GAP): cs_n=1, ad_oe=0.
  - D_SETUP (T_SETUP): cs_n=0, ad_sel=1.
    - Write: ad_oe=1, ad_out=latched dato.
    - Read: ad_oe=0.
  - D_STROBE (T_STROBE): wr_n=0 for a write, rd_n=0 for a read. A read samples ad_in on the last cycle of the strobe.
  - D_HOLD (T_HOLD): strobes high. ad_oe stays at its D_SETUP value.
  - DONE (1 cycle): cs_n=1, ad_oe=0, fin=1. If op=read and the latched write=1, then reg_wr_en=1 with the sampled byte and the latched dir_reg.
  - RECOVER (T_RECOVER): requests are ignored. This covers the sequencer's two-cycle registered response to fin. Then go to IDLE.
- Request inputs are latched only in IDLE. Changes or drops during a transaction are ignored and the transaction always completes.
- A read with write=0 (e.g. the command cycle at address 0xF0) runs fully and issues fin, but no reg_wr_en.
- Total transaction length is 2*(T_SETUP+T_STROBE+T_HOLD)+T_GAP+1 clocks to fin. With defaults, fin comes 29 clocks after the IDLE-exit edge.

Optional Feature:
- Macro: RTC_AD_SYNC_EN.
- Defined: ad_in passes through a 2-flop synchronizer before sampling. The sample point moves to the last cycle of D_HOLD, so the synchronizer is filled from the strobe window. Requires T_HOLD>=2.
- Undefined: ad_in is sampled directly on the last D_STROBE cycle.
- Bus timing and fin timing are identical either way.

Decomposition:
- Shared package: state encoding typedef, default timing constants, op enum (OP_READ, OP_WRITE), and the 8-bit address constants (0xF0 command, 0x21.. clock registers).
- One natural sub-module: rtc_ad_sync (parameterizable 2-flop, 8-bit synchronizer), instantiated only under RTC_AD_SYNC_EN.

Test Plan:
- Write: escritura=1, dirout=0x21, dato=0x45 → address phase drives 0x21 with wr_n low 8 clocks; data phase drives 0x45 with wr_n low 8 clocks; fin pulses at clock 29; reg_wr_en stays 0.
- Captured read: lectura=1, write=1, dirout=0x22, dir_reg=2, ad_in=0x37 during the data strobe → rd_n low 8 clocks; ad_oe=0 in the data phase; reg_wr_en=1 with reg_addr=2, reg_data=0x37 coincident with fin.
- Command read: lectura=1, write=0, dirout=0xF0 → full read cycle, fin=1, reg_wr_en never asserted.
- Priority: lectura=escritura=1 → write transaction (wr_n toggles in the data phase, rd_n stays 1).
- Reset mid-operation: assert reset during A_STROBE → all outputs go to reset values asynchronously, no fin; the next request starts a fresh A_SETUP.
- Recovery: hold lectura=1 continuously → second A_SETUP starts exactly T_RECOVER+1 clocks after fin; requests in RECOVER are ignored. Repeat with RTC_AD_SYNC_EN defined: same fin timing, correct reg_data.

Source files
------------

// File: rtl/rtc_bus_driver_pkg.sv
// Shared types and constants for the RTC multiplexed AD-bus driver.
// Default phase timings, FSM state encoding, op encoding and RTC register addresses.
package rtc_bus_driver_pkg;

  localparam int T_SETUP_DEF   = 2;
  localparam int T_STROBE_DEF  = 8;
  localparam int T_HOLD_DEF    = 2;
  localparam int T_GAP_DEF     = 4;
  localparam int T_RECOVER_DEF = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_A_SETUP,
    ST_A_STROBE,
    ST_A_HOLD,
    ST_GAP,
    ST_D_SETUP,
    ST_D_STROBE,
    ST_D_HOLD,
    ST_DONE,
    ST_RECOVER
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  localparam logic [7:0] ADDR_CMD   = 8'hF0;
  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HOUR  = 8'h23;
  localparam logic [7:0] ADDR_DAY   = 8'h24;
  localparam logic [7:0] ADDR_MONTH = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rtc_ad_sync.sv
// Multi-flop synchronizer for the asynchronous AD bus input (used with RTC_AD_SYNC_EN).
module rtc_ad_sync #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stg [STAGES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) stg[i] <= '0;
    end else begin
      stg[0] <= d;
      for (int i = 1; i < STAGES; i++) stg[i] <= stg[i-1];
    end
  end

  assign q = stg[STAGES-1];

endmodule

// File: rtl/rtc_bus_driver.sv
// Runs one address/data cycle on the RTC multiplexed AD bus per sequencer request.
// Define RTC_AD_SYNC_EN to resynchronise ad_in and sample it at the end of D_HOLD.
module rtc_bus_driver
  import rtc_bus_driver_pkg::*;
#(
  parameter int T_SETUP   = T_SETUP_DEF,
  parameter int T_STROBE  = T_STROBE_DEF,
  parameter int T_HOLD    = T_HOLD_DEF,
  parameter int T_GAP     = T_GAP_DEF,
  parameter int T_RECOVER = T_RECOVER_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dirout,
  input  logic [7:0] dato,
  input  logic       lectura,
  input  logic       escritura,
  input  logic       write,
  input  logic [3:0] dir_reg,
  output logic       fin,
  output logic       cs_n,
  output logic       ad_sel,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] ad_out,
  output logic       ad_oe,
  input  logic [7:0] ad_in,
  output logic       reg_wr_en,
  output logic [3:0] reg_addr,
  output logic [7:0] reg_data
);

  localparam int T_MAX = max_of(max_of(max_of(T_SETUP, T_STROBE), max_of(T_HOLD, T_GAP)),
                                T_RECOVER);
  localparam int CW    = $clog2(T_MAX) + 1;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          last;
  logic          start;

  op_t           op_q;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic          cap_q;
  logic [3:0]    idx_q;

  logic [7:0]    rd_byte;
  logic [7:0]    ad_smp;
  logic          sample_en;

  logic          cs_n_d, ad_sel_d, rd_n_d, wr_n_d, ad_oe_d, fin_d, reg_wr_en_d;
  logic [7:0]    ad_out_d;

  // DONE already counts as the first dead clock, so RECOVER itself is one shorter.
  function automatic logic [CW-1:0] reload(input state_t s);
    case (s)
      ST_A_SETUP, ST_D_SETUP:   reload = CW'(T_SETUP - 1);
      ST_A_STROBE, ST_D_STROBE: reload = CW'(T_STROBE - 1);
      ST_A_HOLD, ST_D_HOLD:     reload = CW'(T_HOLD - 1);
      ST_GAP:                   reload = CW'(T_GAP - 1);
      ST_RECOVER:               reload = CW'(T_RECOVER - 2);
      default:                  reload = '0;
    endcase
  endfunction

  assign last  = (cnt == '0);
  assign start = (state == ST_IDLE) && (escritura || lectura);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = '0;
    cs_n_d      = 1'b1;
    ad_sel_d    = 1'b0;
    rd_n_d      = 1'b1;
    wr_n_d      = 1'b1;
    ad_oe_d     = 1'b0;
    ad_out_d    = ad_out;
    fin_d       = 1'b0;
    reg_wr_en_d = 1'b0;

    case (state)
      ST_IDLE:     if (start) state_nxt = ST_A_SETUP;
      ST_A_SETUP:  if (last) state_nxt = ST_A_STROBE;
      ST_A_STROBE: if (last) state_nxt = ST_A_HOLD;
      ST_A_HOLD:   if (last) state_nxt = ST_GAP;
      ST_GAP:      if (last) state_nxt = ST_D_SETUP;
      ST_D_SETUP:  if (last) state_nxt = ST_D_STROBE;
      ST_D_STROBE: if (last) state_nxt = ST_D_HOLD;
      ST_D_HOLD:   if (last) state_nxt = ST_DONE;
      ST_DONE:     state_nxt = ST_RECOVER;
      ST_RECOVER:  if (last) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase

    if (state_nxt != state)   cnt_nxt = reload(state_nxt);
    else if (state != ST_IDLE) cnt_nxt = cnt - CW'(1);

    case (state)
      ST_A_SETUP, ST_A_STROBE, ST_A_HOLD: begin
        cs_n_d   = 1'b0;
        ad_oe_d  = 1'b1;
        ad_out_d = addr_q;
        wr_n_d   = (state != ST_A_STROBE);
      end
      ST_D_SETUP, ST_D_STROBE, ST_D_HOLD: begin
        cs_n_d   = 1'b0;
        ad_sel_d = 1'b1;
        ad_oe_d  = (op_q == OP_WRITE);
        if (op_q == OP_WRITE) ad_out_d = data_q;
        if (state == ST_D_STROBE) begin
          wr_n_d = (op_q != OP_WRITE);
          rd_n_d = (op_q != OP_READ);
        end
      end
      ST_DONE: begin
        fin_d       = 1'b1;
        reg_wr_en_d = (op_q == OP_READ) && cap_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q   <= OP_READ;
      addr_q <= '0;
      data_q <= '0;
      cap_q  <= 1'b0;
      idx_q  <= '0;
    end else if (start) begin
      op_q   <= escritura ? OP_WRITE : OP_READ;
      addr_q <= dirout;
      data_q <= dato;
      cap_q  <= write;
      idx_q  <= dir_reg;
    end
  end

`ifdef RTC_AD_SYNC_EN
  logic [7:0] ad_in_sync;

  rtc_ad_sync #(
    .WIDTH  (8),
    .STAGES (2)
  ) u_ad_sync (
    .clk (clk),
    .rst (reset),
    .d   (ad_in),
    .q   (ad_in_sync)
  );

  assign sample_en = (state == ST_D_HOLD) && last && (op_q == OP_READ);
  assign ad_smp    = ad_in_sync;
`else
  assign sample_en = (state == ST_D_STROBE) && last && (op_q == OP_READ);
  assign ad_smp    = ad_in;
`endif

  // Outputs are decoded from the current state and registered, so the pins trail the state by one clock.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n      <= 1'b1;
      ad_sel    <= 1'b0;
      rd_n      <= 1'b1;
      wr_n      <= 1'b1;
      ad_oe     <= 1'b0;
      ad_out    <= '0;
      fin       <= 1'b0;
      reg_wr_en <= 1'b0;
      reg_addr  <= '0;
      reg_data  <= '0;
      rd_byte   <= '0;
    end else begin
      cs_n      <= cs_n_d;
      ad_sel    <= ad_sel_d;
      rd_n      <= rd_n_d;
      wr_n      <= wr_n_d;
      ad_oe     <= ad_oe_d;
      ad_out    <= ad_out_d;
      fin       <= fin_d;
      reg_wr_en <= reg_wr_en_d;
      if (sample_en) rd_byte <= ad_smp;
      if (reg_wr_en_d) begin
        reg_addr <= idx_q;
        reg_data <= rd_byte;
      end
    end
  end

endmodule
